// File: rtl/radix4_booth_mul_if.sv
// Operand/result bundle for the radix-4 Booth multiplier.
// Start/clear requests in, busy/done status and product out.
interface radix4_booth_mul_if #(
  parameter int WIDTH = 64
);
  logic                   op_start;
  logic                   op_clear;
  logic                   op_signed;
  logic [WIDTH-1:0]       multiplier;
  logic [WIDTH-1:0]       multiplicand;
  logic                   op_busy;
  logic                   op_done;
  logic [2*WIDTH-1:0]     result;

  modport master (
    output op_start,
    output op_clear,
    output op_signed,
    output multiplier,
    output multiplicand,
    input  op_busy,
    input  op_done,
    input  result
  );

  modport slave (
    input  op_start,
    input  op_clear,
    input  op_signed,
    input  multiplier,
    input  multiplicand,
    output op_busy,
    output op_done,
    output result
  );
endinterface

// File: rtl/radix4_booth_mul.sv
// Sequential radix-4 Booth multiplier, one digit per cycle.
// WIDTH/2+1 digits cover both signed and unsigned operands.
module radix4_booth_mul #(
  parameter int WIDTH = 64
) (
  input logic               clk,
  input logic               reset_n,
  radix4_booth_mul_if.slave bus
);

  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N);
  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH+2:0] mc;
  logic [PW-1:0]    mp;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    res;

  logic [WIDTH+2:0] mc_ext;
  logic [PW-1:0]    mp_ext;
  logic             ext_bit_mc;
  logic             ext_bit_mp;
  logic             one;
  logic             two;
  logic             neg;
  logic [PW-1:0]    mag;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    sum;

  assign ext_bit_mc = bus.op_signed & bus.multiplicand[WIDTH-1];
  assign ext_bit_mp = bus.op_signed & bus.multiplier[WIDTH-1];

  // Recoded operand carries the implicit zero below bit 0.
  assign mc_ext = {{2{ext_bit_mc}}, bus.multiplicand, 1'b0};
  assign mp_ext = {{WIDTH{ext_bit_mp}}, bus.multiplier};

  assign one = mc[1] ^ mc[0];
  assign two = (mc[2:0] == 3'b011) || (mc[2:0] == 3'b100);
  assign neg = mc[2] & ~(mc[1] & mc[0]);

  always_comb begin
    mag = '0;
    unique case (1'b1)
      one:     mag = mp;
      two:     mag = mp << 1;
      default: mag = '0;
    endcase
  end

  assign pp  = neg ? -mag : mag;
  assign sum = acc + pp;

  always_ff @(posedge clk) begin
    if (!reset_n || bus.op_clear) begin
      state <= IDLE;
      cnt   <= '0;
      mc    <= '0;
      mp    <= '0;
      acc   <= '0;
      res   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.op_start) begin
            mc    <= mc_ext;
            mp    <= mp_ext;
            acc   <= '0;
            res   <= '0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Shift the operands so the current digit is always at the bottom.
          acc <= sum;
          mc  <= mc >> 2;
          mp  <= mp << 2;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            res   <= sum;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.op_busy = (state == BUSY);
  assign bus.op_done = (state == DONE);
  assign bus.result  = res;

endmodule

// File: doc/radix4_booth_mul.md
RADIX4_BOOTH_MUL -- requirements
Module: radix4_booth_mul

Interface
REQ-001 Parameter WIDTH, default 64, operand width in bits; SHALL be even and >= 4.
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port reset_n  input  1  reset is synchronous and active-low.
REQ-004 Port op_start  input  1  request to start a multiplication, sampled at the rising edge of clk.
REQ-005 Port op_clear  input  1  synchronous abort/clear; SHALL have priority over op_start.
REQ-006 Port op_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with op_start.
REQ-007 Port multiplier  input  WIDTH  operand added or subtracted per Booth digit; sampled with op_start.
REQ-008 Port multiplicand  input  WIDTH  operand Booth-recoded two bits per cycle; sampled with op_start.
REQ-009 Port op_busy  output  1  high while iterations are in progress.
REQ-010 Port op_done  output  1  high while result holds a completed product.
REQ-011 Port result  output  2*WIDTH  product register.

Function
REQ-012 The FSM SHALL have three states, IDLE, BUSY and DONE, with op_busy = (state==BUSY) and op_done = (state==DONE), both registered-state decodes.
REQ-013 In IDLE or DONE, op_start=1 with op_clear=0 SHALL latch both operands and op_signed, zero the accumulator, result and counter, and move to BUSY.
REQ-014 The latched multiplicand SHALL be extended to WIDTH+2 bits (sign-extended if op_signed, else zero-extended), with an implicit 0 below bit 0.
REQ-015 The latched multiplier SHALL be extended to 2*WIDTH bits using the same rule.
REQ-016 In BUSY, each cycle SHALL consume one radix-4 Booth triplet {m[2i+1],m[2i],m[2i-1]}, i = counter.
REQ-017 Each triplet SHALL add {0,+M,+M,+2M,-2M,-M,-M,0} for triplet values 000..111, shifted left by 2i, modulo 2^(2*WIDTH).
REQ-018 BUSY SHALL last N = WIDTH/2+1 cycles, in both modes; the counter SHALL count 0..N-1.
REQ-019 On the cycle consuming digit N-1, the full product SHALL be written to result and the state SHALL become DONE.
REQ-020 op_done SHALL first be high N cycles after the cycle in which op_start was accepted (N = 33 for WIDTH=64).
REQ-021 result SHALL read 0 throughout BUSY and SHALL hold the product in DONE until the next accepted op_start or op_clear.
REQ-022 op_start during BUSY SHALL be ignored; input operand and mode changes during BUSY SHALL have no effect.
REQ-023 op_start in DONE SHALL begin a new operation per REQ-013 (back-to-back), dropping op_done on the next edge.
REQ-024 op_clear=1 in any state SHALL, on the next edge, force IDLE, zero result, the accumulator and the counter, and deassert op_busy and op_done.
REQ-025 If op_clear and op_start are both high, op_clear SHALL win and op_start SHALL be discarded.
REQ-026 The result SHALL equal the exact product: unsigned x unsigned when op_signed=0, or signed x signed as 2*WIDTH-bit two's complement when op_signed=1.
REQ-027 The product SHALL never overflow 2*WIDTH bits.
REQ-028 The state machine SHALL contain no combinational loops or latches, and every next-state and next-output signal SHALL be assigned on all paths.

Reset
REQ-029 When reset_n=0 at a rising edge, the block SHALL enter IDLE with result=0, op_busy=0, op_done=0, the counter at 0 and the accumulator at 0, regardless of any other input.
REQ-030 Reset SHALL override op_start and op_clear.
REQ-031 Reset asserted mid-BUSY SHALL abandon the operation with no partial result visible.
REQ-032 The first op_start accepted after reset_n returns high SHALL behave per REQ-013.

Verification
REQ-033 WIDTH=64, op_signed=0, both operands 0xFFFF_FFFF_FFFF_FFFF -> op_done after 33 cycles with result 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
REQ-034 WIDTH=64, op_signed=1, both operands 0x8000_0000_0000_0000 -> result 0x4000_0000_0000_0000_0000_0000_0000_0000; op_signed=1 with both operands -1 -> result 1.
REQ-035 WIDTH=8: unsigned 200 x 3 -> 16'h0258 after 5 cycles; signed 8'hC8 x 8'h03 (-56 x 3) -> 16'hFF58.
REQ-036 op_clear at BUSY cycle 10 -> IDLE next edge with result=0 and op_busy=0; a new op_start then gives the correct product with full latency.
REQ-037 op_start pulsed again mid-BUSY with different operands -> ignored, and the original product appears.
REQ-038 op_start in DONE -> back-to-back product correct; simultaneous op_start and op_clear -> IDLE; reset_n low mid-BUSY -> all outputs 0.
